mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM pipeline stage with a handshaked data-memory port.
//
// Non-memory ops pass through to the MEM/WB register with one cycle of latency.
// A load or store stalls the pipeline. It issues a request on the dmem channel,
// waits up to TIMEOUT cycles for dmem_ack, and then writes back on the cycle
// after completion.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   mem_reg_write, mem_mem_read,
//   mem_mem_write, mem_alu_result,
//   mem_write_data, mem_rd, mem_pc EX/MEM register contents
//   dmem_req/we/addr/wdata        data-memory request (registered)
//   dmem_ack, dmem_rdata          data-memory response (rdata valid with ack)
//   stall                         hold upstream pipeline registers (combinational)
//   wb_valid, wb_reg_write, wb_rd,
//   wb_data, wb_pc                MEM/WB register
//   err_clr, err_timeout          sticky timeout flag and its clear
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_reg_write,
    input  logic       mem_mem_read,
    input  logic       mem_mem_write,
    input  logic [7:0] mem_alu_result,
    input  logic [7:0] mem_write_data,
    input  logic [1:0] mem_rd,
    input  logic [7:0] mem_pc,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic       dmem_ack,
    input  logic [7:0] dmem_rdata,
    output logic       stall,
    output logic       wb_valid,
    output logic       wb_reg_write,
    output logic [1:0] wb_rd,
    output logic [7:0] wb_data,
    output logic [7:0] wb_pc,
    input  logic       err_clr,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic       failed_q, failed_d;

    logic       req_d, we_d;
    logic [7:0] addr_d, wdata_d;
    logic       wb_valid_d, wb_reg_write_d;
    logic [1:0] wb_rd_d;
    logic [7:0] wb_data_d, wb_pc_d;
    logic       err_d;

    logic       access;
    assign access = mem_mem_read | mem_mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rdata_q      <= '0;
            failed_q     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_pc        <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            failed_q     <= failed_d;
            dmem_req     <= req_d;
            dmem_we      <= we_d;
            dmem_addr    <= addr_d;
            dmem_wdata   <= wdata_d;
            wb_valid     <= wb_valid_d;
            wb_reg_write <= wb_reg_write_d;
            wb_rd        <= wb_rd_d;
            wb_data      <= wb_data_d;
            wb_pc        <= wb_pc_d;
            err_timeout  <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        failed_d       = failed_q;
        req_d          = dmem_req;
        we_d           = dmem_we;
        addr_d         = dmem_addr;
        wdata_d        = dmem_wdata;
        wb_valid_d     = wb_valid;
        wb_reg_write_d = wb_reg_write;
        wb_rd_d        = wb_rd;
        wb_data_d      = wb_data;
        wb_pc_d        = wb_pc;
        stall          = 1'b0;
        // A timeout raised below overrides the clear in the same cycle.
        err_d          = err_clr ? 1'b0 : err_timeout;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    stall      = 1'b1;
                    addr_d     = mem_alu_result;
                    wdata_d    = mem_write_data;
                    // Read+write together is treated as a write.
                    we_d       = mem_mem_write;
                    cnt_d      = '0;
                    failed_d   = 1'b0;
                    req_d      = 1'b1;
                    wb_valid_d = 1'b0;
                    state_d    = WAIT;
                end else begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = mem_reg_write;
                    wb_rd_d        = mem_rd;
                    wb_data_d      = mem_alu_result;
                    wb_pc_d        = mem_pc;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // An ack on the last permitted cycle is tested first, so it beats the timeout.
                if (dmem_ack) begin
                    if (!dmem_we) begin
                        rdata_d = dmem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == LAST_WAIT) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    rdata_d  = 8'hFF;
                    failed_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                wb_valid_d     = 1'b1;
                wb_reg_write_d = mem_reg_write & ~failed_q;
                wb_rd_d        = mem_rd;
                wb_data_d      = dmem_we ? mem_alu_result : rdata_q;
                wb_pc_d        = mem_pc;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_reg_write, mem_mem_read, mem_mem_write;
    logic [7:0] mem_alu_result, mem_write_data, mem_pc;
    logic [1:0] mem_rd;
    logic       dmem_req, dmem_we, dmem_ack;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic       stall;
    logic       wb_valid, wb_reg_write;
    logic [1:0] wb_rd;
    logic [7:0] wb_data, wb_pc;
    logic       err_clr, err_timeout;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data), .mem_rd(mem_rd), .mem_pc(mem_pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
        .err_clr(err_clr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // One MEM-stage operation. d = WAIT cycle (1-based) on which ack is given;
    // d > T means the memory never answers. clr drives err_clr in the last cycle.
    typedef struct {
        logic        rw, mrd, mwr;
        logic [1:0]  rdreg;
        logic [7:0]  alu, wdata, pc, rdata;
        int unsigned d;
        logic        clr;
    } op_t;

    typedef struct {
        int unsigned stalls, reqs;
        logic [7:0]  wb_data;
        logic        wb_rw;
        logic        err;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic rw, input logic mrd, input logic mwr,
                               input logic [1:0] rdreg, input logic [7:0] alu,
                               input logic [7:0] wdata, input logic [7:0] pc,
                               input logic [7:0] rdata, input int unsigned d, input logic clr);
        op_t o;
        o.rw = rw; o.mrd = mrd; o.mwr = mwr; o.rdreg = rdreg; o.alu = alu;
        o.wdata = wdata; o.pc = pc; o.rdata = rdata; o.d = d; o.clr = clr;
        return o;
    endfunction

    function automatic exp_t mkx(input int unsigned stalls, input int unsigned reqs,
                                 input logic [7:0] wbd, input logic wbrw, input logic err);
        exp_t e;
        e.stalls = stalls; e.reqs = reqs; e.wb_data = wbd; e.wb_rw = wbrw; e.err = err;
        return e;
    endfunction

    // Transaction-level reference: what the stage must produce for a whole op.
    function automatic exp_t model(input op_t o, input logic err_before);
        exp_t e;
        int unsigned n;
        logic to;
        if (!(o.mrd | o.mwr)) begin
            e = mkx(0, 0, o.alu, o.rw, o.clr ? 1'b0 : err_before);
        end else begin
            to = (o.d > T);
            n  = to ? T : o.d;
            e.stalls  = n + 1;
            e.reqs    = n;
            e.wb_data = o.mwr ? o.alu : (to ? 8'hFF : o.rdata);
            e.wb_rw   = o.rw & ~to;
            e.err     = o.clr ? 1'b0 : (err_before | to);
        end
        return e;
    endfunction

    // Starts at posedge+1; returns at posedge+1 just after the write-back edge.
    task automatic run_op(input op_t o, input exp_t e);
        int unsigned stalls = 0, reqs = 0, k = 0;
        bit done = 0;
        mem_reg_write = o.rw; mem_mem_read = o.mrd; mem_mem_write = o.mwr;
        mem_rd = o.rdreg; mem_alu_result = o.alu; mem_write_data = o.wdata; mem_pc = o.pc;
        dmem_ack = 1'b0; err_clr = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (dmem_req) begin
                k++; reqs++;
                chk("dmem_addr", 32'(dmem_addr), 32'(o.alu));
                chk("dmem_we", 32'(dmem_we), 32'(o.mwr));
                chk("dmem_wdata", 32'(dmem_wdata), 32'(o.wdata));
                chk("wb_valid_in_wait", 32'(wb_valid), 32'(0));
                dmem_ack   = (k == o.d);
                dmem_rdata = (k == o.d) ? o.rdata : 8'($urandom);
            end else begin
                // Acks outside WAIT must have no effect.
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = 8'($urandom);
            end
            if (stall) stalls++;
            else begin
                done = 1;
                err_clr = o.clr;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0; err_clr = 1'b0;
        end
        chk("op_completes", 32'(done), 32'(1));
        chk("stall_cycles", stalls, e.stalls);
        chk("req_cycles", reqs, e.reqs);
        chk("wb_valid", 32'(wb_valid), 32'(1));
        chk("wb_rd", 32'(wb_rd), 32'(o.rdreg));
        chk("wb_pc", 32'(wb_pc), 32'(o.pc));
        chk("wb_data", 32'(wb_data), 32'(e.wb_data));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.wb_rw));
        chk("err_timeout", 32'(err_timeout), 32'(e.err));
        chk("dmem_req_after", 32'(dmem_req), 32'(0));
    endtask

    vec_t vecs[10];
    logic err_m;
    int unsigned reqs;
    op_t o;

    initial begin
        vecs[0] = '{mk(1, 0, 0, 2, 8'h3C, 8'h00, 8'h10, 8'h00, 0, 0), mkx(0, 0, 8'h3C, 1, 0)};
        vecs[1] = '{mk(1, 1, 0, 1, 8'h20, 8'h00, 8'h11, 8'hA5, 1, 0), mkx(2, 1, 8'hA5, 1, 0)};
        vecs[2] = '{mk(0, 0, 1, 3, 8'h40, 8'h7E, 8'h12, 8'h00, 4, 0), mkx(5, 4, 8'h40, 0, 0)};
        vecs[3] = '{mk(1, 1, 0, 2, 8'h55, 8'h00, 8'h13, 8'h66, 6, 0), mkx(5, 4, 8'hFF, 0, 1)};
        vecs[4] = '{mk(0, 0, 0, 0, 8'h01, 8'h00, 8'h14, 8'h00, 0, 1), mkx(0, 0, 8'h01, 0, 0)};
        vecs[5] = '{mk(1, 1, 0, 1, 8'h30, 8'h00, 8'h15, 8'h11, 4, 0), mkx(5, 4, 8'h11, 1, 0)};
        vecs[6] = '{mk(1, 1, 1, 2, 8'h77, 8'h99, 8'h16, 8'h33, 2, 0), mkx(3, 2, 8'h77, 1, 0)};
        vecs[7] = '{mk(1, 0, 1, 3, 8'h88, 8'h44, 8'h17, 8'h00, 5, 0), mkx(5, 4, 8'h88, 0, 1)};
        vecs[8] = '{mk(1, 0, 0, 1, 8'hC3, 8'h00, 8'h18, 8'h00, 0, 0), mkx(0, 0, 8'hC3, 1, 1)};
        vecs[9] = '{mk(1, 1, 0, 0, 8'h12, 8'h00, 8'h19, 8'h5A, 6, 1), mkx(5, 4, 8'hFF, 0, 0)};

        // Reset state
        rst = 1'b1;
        {mem_reg_write, mem_mem_read, mem_mem_write, err_clr, dmem_ack} = '0;
        mem_alu_result = '0; mem_write_data = '0; mem_rd = '0; mem_pc = '0; dmem_rdata = '0;
        #12;
        chk("rst_dmem_req", 32'(dmem_req), 32'(0));
        chk("rst_dmem_we", 32'(dmem_we), 32'(0));
        chk("rst_dmem_addr", 32'(dmem_addr), 32'(0));
        chk("rst_wb_valid", 32'(wb_valid), 32'(0));
        chk("rst_wb_data", 32'(wb_data), 32'(0));
        chk("rst_err", 32'(err_timeout), 32'(0));
        chk("rst_stall_idle", 32'(stall), 32'(0));
        mem_mem_read = 1'b1; #1;
        chk("rst_stall_access", 32'(stall), 32'(1));
        mem_mem_read = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) run_op(vecs[i].op, vecs[i].ex);
        err_m = vecs[9].ex.err;

        // Timeout coinciding with err_clr: timeout wins, clear acts one edge later
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_mem_write = 1'b0;
        mem_alu_result = 8'h5E; mem_rd = 2'd1; mem_pc = 8'h20;
        err_clr = 1'b1; dmem_ack = 1'b0;
        reqs = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (dmem_req) reqs++;
            else if (reqs > 0) break;
        end
        chk("prio_req_cycles", reqs, T);
        chk("prio_err_set", 32'(err_timeout), 32'(1));
        chk("prio_stall_resp", 32'(stall), 32'(0));
        @(posedge clk); #1;
        chk("prio_err_cleared", 32'(err_timeout), 32'(0));
        chk("prio_wb_data", 32'(wb_data), 32'(8'hFF));
        chk("prio_wb_rw", 32'(wb_reg_write), 32'(0));
        err_clr = 1'b0; mem_mem_read = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of WAIT
        run_op(mk(0, 1, 0, 0, 8'h01, 8'h00, 8'h21, 8'h00, 9, 0), mkx(5, 4, 8'hFF, 0, 1));
        mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_alu_result = 8'h6A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midwait_req", 32'(dmem_req), 32'(1));
        #2 rst = 1'b1; #1;
        chk("rstwait_req", 32'(dmem_req), 32'(0));
        chk("rstwait_wb_valid", 32'(wb_valid), 32'(0));
        chk("rstwait_err", 32'(err_timeout), 32'(0));
        chk("rstwait_stall", 32'(stall), 32'(1));
        mem_mem_read = 1'b0; #1;
        chk("rstwait_stall_idle", 32'(stall), 32'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op(mk(1, 0, 0, 3, 8'hB4, 8'h00, 8'h22, 8'h00, 0, 0), mkx(0, 0, 8'hB4, 1, 0));
        err_m = 1'b0;

        // Randomized ops against the transaction model
        for (int i = 0; i < 150; i++) begin
            exp_t e;
            o.rw = 1'($urandom); o.mrd = 1'($urandom); o.mwr = 1'($urandom);
            o.rdreg = 2'($urandom); o.alu = 8'($urandom); o.wdata = 8'($urandom);
            o.pc = 8'($urandom); o.rdata = 8'($urandom);
            o.d = $urandom_range(1, T + 2);
            o.clr = ($urandom_range(0, 3) == 0);
            e = model(o, err_m);
            run_op(o, e);
            err_m = e.err;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
